// File: rtl/pe_array_ctrl.sv
// Control sequencer for a SIZE x SIZE weight-stationary systolic array.
// It loads a weight tile, latches it with preclk, and streams num_vec input
// vectors with per-row skew. It then raises output-memory write strobes as
// results leave the array. All outputs come straight from flops: the next
// value of each output is decoded from the next state and registered.
module pe_array_ctrl #(
  parameter int SIZE     = 4,
  parameter int AW       = 8,
  parameter int PIPE_LAT = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [AW-1:0]   num_vec_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            cfg_err_o,
  output logic            w_rd_en_o,
  output logic [AW-1:0]   w_rd_addr_o,
  output logic            w_shift_o,
  output logic            preclk_o,
  output logic            in_rd_en_o,
  output logic [AW-1:0]   in_rd_addr_o,
  output logic [SIZE-1:0] skew_valid_o,
  output logic            out_wr_en_o,
  output logic [AW-1:0]   out_wr_addr_o
);

  localparam int WW = $clog2(SIZE + 1);
  // One extra bit so PIPE_LAT + num_vec never wraps, even for num_vec = 2^AW-1
  localparam int TW = AW + 1;

  typedef enum logic [2:0] {IDLE, LOAD_W, LATCH, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   w_q, w_d;
  logic [TW-1:0]   t_q, t_d;
  logic [AW-1:0]   nv_q, nv_d;
  logic [TW-1:0]   run_last;
  logic [TW-1:0]   nv_ext_d;
  logic [TW-1:0]   out_idx_d;

  logic            busy_d, done_d, cfg_err_d;
  logic            w_rd_en_d, w_shift_d, preclk_d, in_rd_en_d, out_wr_en_d;
  logic [AW-1:0]   w_rd_addr_d, in_rd_addr_d, out_wr_addr_d;
  logic [SIZE-1:0] skew_valid_d;

  // State, counters and latched vector count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      w_q     <= '0;
      t_q     <= '0;
      nv_q    <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      t_q     <= t_d;
      nv_q    <= nv_d;
    end
  end

  // Next-state and counter logic; abort overrides every transition
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    t_d       = t_q;
    nv_d      = nv_q;
    cfg_err_d = 1'b0;
    run_last  = TW'(PIPE_LAT) + {1'b0, nv_q} - TW'(1);
    if (abort_i) begin
      state_d = IDLE;
      w_d     = '0;
      t_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (num_vec_i != '0) begin
              nv_d    = num_vec_i;
              state_d = LOAD_W;
              w_d     = '0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        LOAD_W: begin
          if (w_q == WW'(SIZE)) begin
            state_d = LATCH;
            w_d     = '0;
          end else begin
            w_d = w_q + WW'(1);
          end
        end
        LATCH: begin
          state_d = RUN;
          t_d     = '0;
        end
        RUN: begin
          if (t_q == run_last) begin
            state_d = DONE;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next output values decoded from the next state so outputs are flop-driven
  always_comb begin
    nv_ext_d      = {1'b0, nv_d};
    out_idx_d     = t_d - TW'(PIPE_LAT);
    busy_d        = (state_d == LOAD_W) || (state_d == LATCH) || (state_d == RUN);
    done_d        = (state_d == DONE);
    w_rd_en_d     = (state_d == LOAD_W) && (w_d < WW'(SIZE));
    w_rd_addr_d   = w_rd_en_d ? AW'(w_d) : '0;
    // Weight data arrives one cycle after each read, so shifting lags by one
    w_shift_d     = (state_d == LOAD_W) && (w_d != '0);
    preclk_d      = (state_d == LATCH);
    in_rd_en_d    = (state_d == RUN) && (t_d < nv_ext_d);
    in_rd_addr_d  = in_rd_en_d ? t_d[AW-1:0] : '0;
    out_wr_en_d   = (state_d == RUN) && (t_d >= TW'(PIPE_LAT)) &&
                    (t_d < TW'(PIPE_LAT) + nv_ext_d);
    out_wr_addr_d = out_wr_en_d ? out_idx_d[AW-1:0] : '0;
  end

  // Row r sees its first element r cycles after row 0 (diagonal skew)
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_skew
    assign skew_valid_d[gi] = (state_d == RUN) && (t_d >= TW'(gi)) &&
                              (t_d < TW'(gi) + nv_ext_d);
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      cfg_err_o     <= 1'b0;
      w_rd_en_o     <= 1'b0;
      w_rd_addr_o   <= '0;
      w_shift_o     <= 1'b0;
      preclk_o      <= 1'b0;
      in_rd_en_o    <= 1'b0;
      in_rd_addr_o  <= '0;
      skew_valid_o  <= '0;
      out_wr_en_o   <= 1'b0;
      out_wr_addr_o <= '0;
    end else begin
      busy_o        <= busy_d;
      done_o        <= done_d;
      cfg_err_o     <= cfg_err_d;
      w_rd_en_o     <= w_rd_en_d;
      w_rd_addr_o   <= w_rd_addr_d;
      w_shift_o     <= w_shift_d;
      preclk_o      <= preclk_d;
      in_rd_en_o    <= in_rd_en_d;
      in_rd_addr_o  <= in_rd_addr_d;
      skew_valid_o  <= skew_valid_d;
      out_wr_en_o   <= out_wr_en_d;
      out_wr_addr_o <= out_wr_addr_d;
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed testbench for pe_array_ctrl (SIZE=4, AW=8, PIPE_LAT=8).
// Outputs are sampled on the falling edge; "cycle c" is the period after
// rising edge c, with the start command presented during cycle 0.
module tb_pe_array_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [7:0] num_vec_i = '0;
  logic       busy_o, done_o, cfg_err_o, w_rd_en_o, w_shift_o, preclk_o;
  logic       in_rd_en_o, out_wr_en_o;
  logic [7:0] w_rd_addr_o, in_rd_addr_o, out_wr_addr_o;
  logic [3:0] skew_valid_o;
  logic [35:0] obs;
  logic [35:0] exp_v;

  int checks = 0;
  int errors = 0;

  pe_array_ctrl #(.SIZE(4), .AW(8), .PIPE_LAT(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .num_vec_i    (num_vec_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cfg_err_o    (cfg_err_o),
    .w_rd_en_o    (w_rd_en_o),
    .w_rd_addr_o  (w_rd_addr_o),
    .w_shift_o    (w_shift_o),
    .preclk_o     (preclk_o),
    .in_rd_en_o   (in_rd_en_o),
    .in_rd_addr_o (in_rd_addr_o),
    .skew_valid_o (skew_valid_o),
    .out_wr_en_o  (out_wr_en_o),
    .out_wr_addr_o(out_wr_addr_o)
  );

  always #5 clk_i = ~clk_i;

  assign obs = {busy_o, done_o, cfg_err_o, w_rd_en_o, w_rd_addr_o, w_shift_o,
                preclk_o, in_rd_en_o, in_rd_addr_o, skew_valid_o, out_wr_en_o,
                out_wr_addr_o};

  // Expected outputs in cycle c of a job of n vectors accepted at cycle 0:
  // LOAD_W 1..5, LATCH 6, RUN 7..14+n, DONE 15+n.
  function automatic logic [35:0] exp_out(int c, int n);
    logic       busy, done, wen, ws, pc, ien, oen;
    logic [7:0] wa, ia, oa;
    logic [3:0] sk;
    int t;
    busy = (c >= 1) && (c <= 14 + n);
    done = (c == 15 + n);
    wen  = (c >= 1) && (c <= 4);
    wa   = wen ? 8'(c - 1) : 8'd0;
    ws   = (c >= 2) && (c <= 5);
    pc   = (c == 6);
    t    = c - 7;
    ien  = (t >= 0) && (t < n);
    ia   = ien ? 8'(t) : 8'd0;
    for (int r = 0; r < 4; r++) sk[r] = (t >= r) && (t < r + n);
    oen  = (t >= 8) && (t < 8 + n);
    oa   = oen ? 8'(t - 8) : 8'd0;
    return {busy, done, 1'b0, wen, wa, ws, pc, ien, ia, sk, oen, oa};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    checks++;
    if (obs !== 36'd0) begin
      errors++;
      $display("FAIL reset: outputs got %h want %h", obs, 36'd0);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs !== 36'd0) begin
      errors++;
      $display("FAIL reset_release: outputs got %h want %h", obs, 36'd0);
    end
    $display("test_reset done");
  endtask

  task automatic test_nominal();
    start_i = 1'b1; num_vec_i = 8'd3;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      checks++;
      if (obs !== exp_out(c, 3)) begin
        errors++;
        $display("FAIL nominal cyc %0d: got %h want %h", c, obs, exp_out(c, 3));
      end
    end
    $display("test_nominal n=3 done");
  endtask

  task automatic test_cfg_err();
    start_i = 1'b1; num_vec_i = 8'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    exp_v = '0; exp_v[33] = 1'b1;
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL cfg_err pulse: got %h want %h", obs, exp_v);
    end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== 36'd0) begin
        errors++;
        $display("FAIL cfg_err after cyc %0d: got %h want %h", c, obs, 36'd0);
      end
    end
    $display("test_cfg_err done");
  endtask

  task automatic test_single();
    start_i = 1'b1; num_vec_i = 8'd1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      checks++;
      if (obs !== exp_out(c, 1)) begin
        errors++;
        $display("FAIL single cyc %0d: got %h want %h", c, obs, exp_out(c, 1));
      end
    end
    $display("test_single n=1 done");
  endtask

  task automatic test_abort();
    start_i = 1'b1; num_vec_i = 8'd5;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      checks++;
      if (obs !== exp_out(c, 5)) begin
        errors++;
        $display("FAIL abort_pre cyc %0d: got %h want %h", c, obs, exp_out(c, 5));
      end
    end
    // cycle 9 is RUN with t=2
    abort_i = 1'b1;
    for (int c = 10; c <= 12; c++) begin
      @(negedge clk_i);
      abort_i = 1'b0;
      checks++;
      if (obs !== 36'd0) begin
        errors++;
        $display("FAIL abort_idle cyc %0d: got %h want %h", c, obs, 36'd0);
      end
    end
    start_i = 1'b1; num_vec_i = 8'd2;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      checks++;
      if (obs !== exp_out(c, 2)) begin
        errors++;
        $display("FAIL abort_restart cyc %0d: got %h want %h", c, obs, exp_out(c, 2));
      end
    end
    $display("test_abort done");
  endtask

  task automatic test_async_reset();
    start_i = 1'b1; num_vec_i = 8'd4;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      checks++;
      if (obs !== exp_out(c, 4)) begin
        errors++;
        $display("FAIL areset_pre cyc %0d: got %h want %h", c, obs, exp_out(c, 4));
      end
    end
    // cycle 3 is LOAD_W with w=2; assert reset between clock edges
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (obs !== 36'd0) begin
      errors++;
      $display("FAIL areset_immediate: got %h want %h", obs, 36'd0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++;
      if (obs !== 36'd0) begin
        errors++;
        $display("FAIL areset_hold %0d: got %h want %h", c, obs, 36'd0);
      end
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if (obs !== 36'd0) begin
      errors++;
      $display("FAIL areset_idle: got %h want %h", obs, 36'd0);
    end
    start_i = 1'b1; num_vec_i = 8'd2;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      checks++;
      if (obs !== exp_out(c, 2)) begin
        errors++;
        $display("FAIL areset_restart cyc %0d: got %h want %h", c, obs, exp_out(c, 2));
      end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_back_to_back();
    int dones;
    dones = 0;
    start_i = 1'b1; num_vec_i = 8'd2;
    // job 1 accepted at cycle 0, done at 17; job 2 accepted in IDLE cycle 18
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_i);
      if (c == 35) start_i = 1'b0;
      if (done_o === 1'b1) dones++;
      exp_v = (c <= 18) ? exp_out(c, 2) : exp_out(c - 18, 2);
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL b2b cyc %0d: got %h want %h", c, obs, exp_v);
      end
    end
    checks++;
    if (dones !== 2) begin
      errors++;
      $display("FAIL b2b done_count: got %0d want %0d", dones, 2);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_max();
    start_i = 1'b1; num_vec_i = 8'd255;
    for (int c = 1; c <= 272; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      checks++;
      if (obs !== exp_out(c, 255)) begin
        errors++;
        $display("FAIL max cyc %0d: got %h want %h", c, obs, exp_out(c, 255));
      end
    end
    $display("test_max n=255 done");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_cfg_err();
    test_single();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
- Sequencer for a SIZE x SIZE weight-stationary systolic array of pe tiles.
- Loads one weight tile from weight memory, pulses preclk to latch the weights, and streams num_vec input vectors with per-row skew.
- Generates output-memory write strobes when results leave the array through the final carry-propagate adders.
- Sits between the host command interface and the array and its SRAMs; contains no datapath, only control.

Parameters:
- SIZE, 4, array dimension (rows = columns = weight rows loaded).
- AW, 8, address width for weight, input and output memories and for num_vec.
- PIPE_LAT, 8, cycles from the first in_rd_en to the first valid array output row (read latency + skew + PE pipeline + cpa).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe, sampled only in IDLE.
- abort  in  1  synchronous abort, any state.
- num_vec  in  AW  vectors to stream, sampled with start.
- busy  out  1  high from the cycle after start acceptance until the done cycle.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- w_rd_en  out  1  weight SRAM read enable; data returns next cycle.
- w_rd_addr  out  AW  weight row address.
- w_shift  out  1  shift returned weight row into the array columns.
- preclk  out  1  one-cycle weight latch strobe to all PEs.
- in_rd_en  out  1  input SRAM read enable.
- in_rd_addr  out  AW  input vector index.
- skew_valid  out  SIZE  bit r: row r input lane carries a valid element this cycle.
- out_wr_en  out  1  output SRAM write enable.
- out_wr_addr  out  AW  output vector index.

Behaviour:
- Reset (async, rst_n=0): state IDLE, all counters 0, every output 0. Reset mid-operation abandons the job; no done pulse.
- States: IDLE, LOAD_W, LATCH, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 with num_vec!=0: latch num_vec, go to LOAD_W, w=0.
  - start=1 with num_vec==0: cfg_err=1 for one cycle, stay in IDLE.
  - start is ignored in every other state.
- LOAD_W: SIZE+1 cycles, counter w=0..SIZE.
  - w_rd_en=1 and w_rd_addr=w while w<SIZE.
  - w_shift=1 while w>=1, covering the 1-cycle read latency.
  - After w==SIZE, go to LATCH.
- LATCH: one cycle, preclk=1, then RUN with t=0.
- RUN: counter t, width AW+1; the sum PIPE_LAT+num_vec must not overflow it.
  - in_rd_en=1 and in_rd_addr=t when t<num_vec.
  - skew_valid[r]=1 when r<=t<r+num_vec.
  - out_wr_en=1 and out_wr_addr=t-PIPE_LAT when PIPE_LAT<=t<PIPE_LAT+num_vec.
  - At t==PIPE_LAT+num_vec-1, go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- busy=1 in LOAD_W, LATCH and RUN.
- abort=1: next cycle IDLE with all strobes 0, no done. Abort takes priority over every transition.
- Same-cycle start in DONE is ignored. start is accepted in the first cycle of IDLE after DONE.
- num_vec=2^AW-1 (max) must complete without counter wrap.
- Address outputs hold 0 whenever their enable is 0.

Test Plan:
1. Reset then start=1, num_vec=3 at cycle 0, SIZE=4, PIPE_LAT=8:
   - w_rd_en cycles 1-4, addr 0,1,2,3.
   - w_shift cycles 2-5.
   - preclk cycle 6.
   - in_rd_en cycles 7-9, addr 0-2.
   - skew_valid[3] cycles 10-12.
   - out_wr_en cycles 15-17, addr 0-2.
   - done cycle 18; busy cycles 1-17.
2. start with num_vec=0 -> cfg_err=1 for exactly one cycle, busy stays 0, no memory strobes.
3. num_vec=1 -> skew_valid walks one-hot bit 0..3 over cycles 7-10; single out_wr_en at cycle 15, addr 0; done at cycle 16.
4. abort=1 during RUN at t=2 -> next cycle all outputs 0, state IDLE, no done. A following start, num_vec=2, completes normally.
5. rst_n pulsed low asynchronously mid-LOAD_W (w=2) -> outputs 0 immediately, no preclk ever issued. A restart reloads from w_rd_addr 0.
6. start held high continuously with num_vec=2 -> back-to-back jobs, the second accepted in the IDLE cycle after done. Pulses while busy are ignored: exactly one done per job.
